// File: rtl/timer_microondas_pkg.sv
// rtl/timer_microondas_pkg.sv - shared constants for the microwave cooking timer
package timer_microondas_pkg;

  // Timer state encodings
  localparam logic [1:0] ST_ZERO  = 2'd0;
  localparam logic [1:0] ST_SET   = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  // Largest BCD digit, and the value seconds-tens reloads to on a minute borrow
  localparam logic [3:0] BCD_MAX         = 4'd9;
  localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;

  // Clock cycles per one-second tick at the 100 ms simulation timescale
  localparam int TICK_DIV_DEFAULT = 10;

  // Keypad codes 10-15 are not digits and must be ignored
  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit of the countdown with load and borrow
module bcd_down_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic [3:0] reload_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // A decrement from 0 wraps to the reload value and borrows from the next digit
  assign borrow_out = dec && (digit == 4'd0);

  // Load wins over decrement; clear and key entry both arrive through load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec) begin
      digit <= (digit == 4'd0) ? reload_val : digit - 4'd1;
    end
  end

endmodule

// File: rtl/timer_microondas.sv
// rtl/timer_microondas.sv - MM:SS BCD countdown timer driven by mag_on
module timer_microondas
  import timer_microondas_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int PRESC_W  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse
);

  logic [PRESC_W-1:0] presc_q;
  logic [1:0]         state_q;
  logic               done_pulse_q;
  logic               count_zero;
  logic               last_second;
  logic               run;
  logic               tick;
  logic               key_ok;
  logic               load;
  logic [3:0]         ld_mt, ld_mo, ld_st, ld_so;
  logic               b_so, b_st, b_mo;
  logic               unused_borrow;

  assign count_zero  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'd0);
  assign last_second = ({min_tens, min_ones, sec_tens} == 12'd0) && (sec_ones == 4'd1);
  assign run         = mag_on && !count_zero;
  // Clear has priority, so a tick in a clearing cycle is swallowed
  assign tick        = clearn && run && (presc_q == PRESC_W'(TICK_DIV - 1));
  assign key_ok      = clearn && !mag_on && key_valid && is_bcd(key_code);
  assign load        = !clearn || key_ok;

  // Load value: shifted digits for a key, zeros for a clear
  always_comb begin
    ld_mt = 4'd0;
    ld_mo = 4'd0;
    ld_st = 4'd0;
    ld_so = 4'd0;
    if (key_ok) begin
      ld_mt = min_ones;
      ld_mo = sec_tens;
      ld_st = sec_ones;
      ld_so = key_code;
    end
  end

  bcd_down_digit u_sec_ones (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_so), .dec(tick),
    .reload_val(BCD_MAX), .digit(sec_ones), .borrow_out(b_so)
  );

  bcd_down_digit u_sec_tens (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_st), .dec(b_so),
    .reload_val(SEC_TENS_RELOAD), .digit(sec_tens), .borrow_out(b_st)
  );

  bcd_down_digit u_min_ones (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_mo), .dec(b_st),
    .reload_val(BCD_MAX), .digit(min_ones), .borrow_out(b_mo)
  );

  // Ticks only happen on a nonzero count, so the top digit never borrows out
  bcd_down_digit u_min_tens (
    .clk(clk), .reset(reset), .load(load), .load_val(ld_mt), .dec(b_mo),
    .reload_val(BCD_MAX), .digit(min_tens), .borrow_out(unused_borrow)
  );

  // Sub-second prescaler: runs while counting, holds while paused, zeroed at 00:00
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (!clearn) begin
      presc_q <= '0;
    end else if (run) begin
      presc_q <= (presc_q == PRESC_W'(TICK_DIV - 1)) ? '0 : presc_q + PRESC_W'(1);
    end else if (count_zero) begin
      presc_q <= '0;
    end
  end

  // Registered state and buzzer pulse for a tick that lands on 00:00
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ZERO;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= count_zero ? ST_ZERO : (mag_on ? ST_COUNT : ST_SET);
      done_pulse_q <= tick && last_second && (state_q == ST_COUNT);
    end
  end

  assign timer_done = count_zero;
  assign done_pulse = done_pulse_q;

endmodule
